// File: rtl/tournament_bpu.sv
// Tournament branch predictor: per-PC local two-level predictor, global predictor and a choice table.
// Optional feature macro BPU_GSHARE_EN: when defined the global index is GHR ^ PC (gshare), else GHR only (GAg).
module tournament_bpu #(
    parameter int LHT_DEPTH  = 10,
    parameter int LHR_WIDTH  = 6,
    parameter int GHR_WIDTH  = 8,
    parameter int CPHT_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic [31:0] instrD,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        stallE,
    input  logic        flushE,
    input  logic        stallM,
    input  logic        flushM,
    input  logic [31:0] pcM,
    input  logic        branchM,
    input  logic        actual_takeM,
    output logic        branchD,
    output logic        pred_takeD
);

    localparam int LHT_N  = 1 << LHT_DEPTH;
    localparam int LPHT_N = 1 << LHR_WIDTH;
    localparam int GPHT_N = 1 << GHR_WIDTH;
    localparam int CPHT_N = 1 << CPHT_DEPTH;
    localparam int SNAP_W = LHR_WIDTH + GHR_WIDTH + 3;

    localparam logic [1:0] CNT_WEAK_NT = 2'b01;
    localparam logic [1:0] CNT_WEAK_T  = 2'b10;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            if (cnt == 2'b11) begin
                nxt = 2'b11;
            end else begin
                nxt = cnt + 2'b01;
            end
        end else begin
            if (cnt == 2'b00) begin
                nxt = 2'b00;
            end else begin
                nxt = cnt - 2'b01;
            end
        end
        return nxt;
    endfunction

    function automatic logic is_cond_branch(input logic [31:0] instr);
        logic res;
        case (instr[31:26])
            6'b000100, 6'b000101, 6'b000110, 6'b000111: res = 1'b1;
            6'b000001: begin
                case (instr[20:16])
                    5'b00000, 5'b00001, 5'b10000, 5'b10001: res = 1'b1;
                    default: res = 1'b0;
                endcase
            end
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [LHT_N-1:0][LHR_WIDTH-1:0] lht_q;
    logic [LPHT_N-1:0][1:0]          lpht_q;
    logic [GPHT_N-1:0][1:0]          gpht_q;
    logic [CPHT_N-1:0][1:0]          cpht_q;
    logic [GHR_WIDTH-1:0]            ghr_q;

    logic [SNAP_W-1:0] snap_dec_q;
    logic [SNAP_W-1:0] snap_exe_q;
    logic [SNAP_W-1:0] snap_mem_q;
    logic [SNAP_W-1:0] snap_dec_d;
    logic [SNAP_W-1:0] snap_exe_d;
    logic [SNAP_W-1:0] snap_mem_d;

    logic [LHR_WIDTH-1:0]  lhr_f_s;
    logic [GHR_WIDTH-1:0]  gidx_f_s;
    logic                  pl_f_s;
    logic                  pg_f_s;
    logic                  choice_f_s;
    logic                  pred_f_s;
    logic [SNAP_W-1:0]     snap_f_s;

    logic [LHR_WIDTH-1:0]  lhr_m_s;
    logic [GHR_WIDTH-1:0]  gidx_m_s;
    logic                  pl_m_s;
    logic                  pg_m_s;
    logic [CPHT_DEPTH-1:0] cpht_idx_m_s;
    logic [LHT_DEPTH-1:0]  lht_idx_m_s;
    logic [LHR_WIDTH-1:0]  lht_wr_s;
    logic [1:0]            lpht_wr_s;
    logic [1:0]            gpht_wr_s;
    logic [1:0]            cpht_wr_s;
    logic                  unused_s;

    // Fetch-stage lookup of all three structures; reads see table state before this edge's update.
    always_comb begin
        lhr_f_s = lht_q[pcF[LHT_DEPTH+1:2]];
`ifdef BPU_GSHARE_EN
        gidx_f_s = ghr_q ^ pcF[GHR_WIDTH+1:2];
`else
        gidx_f_s = ghr_q;
`endif
        pl_f_s     = lpht_q[lhr_f_s][1];
        pg_f_s     = gpht_q[gidx_f_s][1];
        choice_f_s = cpht_q[pcF[CPHT_DEPTH+1:2]][1];
        pred_f_s   = choice_f_s ? pg_f_s : pl_f_s;
        snap_f_s   = {lhr_f_s, gidx_f_s, pl_f_s, pg_f_s, pred_f_s};
    end

    // Snapshot stage controls: flush clears, stall holds, otherwise advance.
    always_comb begin
        if (flushD) begin
            snap_dec_d = '0;
        end else if (stallD) begin
            snap_dec_d = snap_dec_q;
        end else begin
            snap_dec_d = snap_f_s;
        end
        if (flushE) begin
            snap_exe_d = '0;
        end else if (stallE) begin
            snap_exe_d = snap_exe_q;
        end else begin
            snap_exe_d = snap_dec_q;
        end
        if (flushM) begin
            snap_mem_d = '0;
        end else if (stallM) begin
            snap_mem_d = snap_mem_q;
        end else begin
            snap_mem_d = snap_exe_q;
        end
    end

    // Training values derived from the Memory-stage snapshot, so the entries read at lookup are the ones trained.
    always_comb begin
        lhr_m_s      = snap_mem_q[SNAP_W-1 -: LHR_WIDTH];
        gidx_m_s     = snap_mem_q[GHR_WIDTH+2:3];
        pl_m_s       = snap_mem_q[2];
        pg_m_s       = snap_mem_q[1];
        lht_idx_m_s  = pcM[LHT_DEPTH+1:2];
        cpht_idx_m_s = pcM[CPHT_DEPTH+1:2];
        lht_wr_s     = {lhr_m_s[LHR_WIDTH-2:0], actual_takeM};
        lpht_wr_s    = sat_update(lpht_q[lhr_m_s], actual_takeM);
        gpht_wr_s    = sat_update(gpht_q[gidx_m_s], actual_takeM);
        if (pl_m_s != pg_m_s) begin
            cpht_wr_s = sat_update(cpht_q[cpht_idx_m_s], pg_m_s == actual_takeM);
        end else begin
            cpht_wr_s = cpht_q[cpht_idx_m_s];
        end
    end

    // Snapshot pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_dec_q <= '0;
            snap_exe_q <= '0;
            snap_mem_q <= '0;
        end else begin
            snap_dec_q <= snap_dec_d;
            snap_exe_q <= snap_exe_d;
            snap_mem_q <= snap_mem_d;
        end
    end

    // Predictor tables and non-speculative global history; written only by a resolved branch in Memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lht_q  <= '0;
            lpht_q <= {LPHT_N{CNT_WEAK_T}};
            gpht_q <= {GPHT_N{CNT_WEAK_T}};
            cpht_q <= {CPHT_N{CNT_WEAK_NT}};
            ghr_q  <= '0;
        end else if (branchM) begin
            lht_q[lht_idx_m_s]   <= lht_wr_s;
            lpht_q[lhr_m_s]      <= lpht_wr_s;
            gpht_q[gidx_m_s]     <= gpht_wr_s;
            cpht_q[cpht_idx_m_s] <= cpht_wr_s;
            ghr_q                <= {ghr_q[GHR_WIDTH-2:0], actual_takeM};
        end
    end

    assign branchD    = is_cond_branch(instrD);
    assign pred_takeD = branchD & snap_dec_q[0];

    assign unused_s = &{1'b0, pcF, pcM, instrD, snap_mem_q[0]};

endmodule

// File: tb/tb_tournament_bpu.sv
// Directed and randomized bench for tournament_bpu, checked against a behavioural integer model.
// Honours BPU_GSHARE_EN the same way as the design.
module tb_tournament_bpu;

    localparam logic [31:0] BEQ    = 32'h1000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] FILLPC = 32'h0040_0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pcF = 32'd0;
    logic [31:0] instrD = 32'd0;
    logic        stallD = 1'b0, flushD = 1'b0;
    logic        stallE = 1'b0, flushE = 1'b0;
    logic        stallM = 1'b0, flushM = 1'b0;
    logic [31:0] pcM = 32'd0;
    logic        branchM = 1'b0;
    logic        actual_takeM = 1'b0;
    logic        branchD;
    logic        pred_takeD;

    int checks = 0;
    int failures = 0;

    int m_lht [1024];
    int m_lpht[64];
    int m_gpht[256];
    int m_cpht[256];
    int m_ghr;
    int s_lhr[3], s_gidx[3], s_pl[3], s_pg[3], s_pred[3];
    int exp_pred;

    tournament_bpu #(
        .LHT_DEPTH(10), .LHR_WIDTH(6), .GHR_WIDTH(8), .CPHT_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .pcF(pcF), .instrD(instrD),
        .stallD(stallD), .flushD(flushD), .stallE(stallE), .flushE(flushE),
        .stallM(stallM), .flushM(flushM), .pcM(pcM), .branchM(branchM),
        .actual_takeM(actual_takeM), .branchD(branchD), .pred_takeD(pred_takeD)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int exp_branch(input logic [31:0] ins);
        int op = int'(ins >> 26);
        int rt = int'((ins >> 16) % 32'd32);
        if (op >= 4 && op <= 7) return 1;
        if (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)) return 1;
        return 0;
    endfunction

    function automatic int sat(input int c, input int taken);
        if (taken != 0) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        foreach (m_lht[i])  m_lht[i]  = 0;
        foreach (m_lpht[i]) m_lpht[i] = 2;
        foreach (m_gpht[i]) m_gpht[i] = 2;
        foreach (m_cpht[i]) m_cpht[i] = 1;
        m_ghr = 0;
        for (int s = 0; s < 3; s++) begin
            s_lhr[s] = 0; s_gidx[s] = 0; s_pl[s] = 0; s_pg[s] = 0; s_pred[s] = 0;
        end
    endtask

    task automatic move(input int dst, input logic fl, input logic st,
                        input int lhr, input int gidx, input int pl, input int pg, input int pr);
        if (fl) begin
            s_lhr[dst] = 0; s_gidx[dst] = 0; s_pl[dst] = 0; s_pg[dst] = 0; s_pred[dst] = 0;
        end else if (!st) begin
            s_lhr[dst] = lhr; s_gidx[dst] = gidx; s_pl[dst] = pl; s_pg[dst] = pg; s_pred[dst] = pr;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare both outputs.
    task automatic step(input logic [31:0] pc_f, input logic [31:0] ins,
                        input logic [31:0] pc_m, input logic br, input logic tk);
        int lhr, gidx, pl, pg, pr, li, ci, t;
        pcF = pc_f; instrD = ins; pcM = pc_m; branchM = br; actual_takeM = tk;
        @(posedge clk);
        lhr = m_lht[int'((pc_f >> 2) % 32'd1024)];
`ifdef BPU_GSHARE_EN
        gidx = m_ghr ^ int'((pc_f >> 2) % 32'd256);
`else
        gidx = m_ghr;
`endif
        pl = (m_lpht[lhr] >= 2) ? 1 : 0;
        pg = (m_gpht[gidx] >= 2) ? 1 : 0;
        pr = (m_cpht[int'((pc_f >> 2) % 32'd256)] >= 2) ? pg : pl;
        if (br) begin
            t  = tk ? 1 : 0;
            li = int'((pc_m >> 2) % 32'd1024);
            ci = int'((pc_m >> 2) % 32'd256);
            m_lht[li] = (s_lhr[2] * 2 + t) % 64;
            m_lpht[s_lhr[2]] = sat(m_lpht[s_lhr[2]], t);
            m_gpht[s_gidx[2]] = sat(m_gpht[s_gidx[2]], t);
            if (s_pl[2] != s_pg[2]) m_cpht[ci] = sat(m_cpht[ci], (s_pg[2] == t) ? 1 : 0);
            m_ghr = (m_ghr * 2 + t) % 256;
        end
        move(2, flushM, stallM, s_lhr[1], s_gidx[1], s_pl[1], s_pg[1], s_pred[1]);
        move(1, flushE, stallE, s_lhr[0], s_gidx[0], s_pl[0], s_pg[0], s_pred[0]);
        move(0, flushD, stallD, lhr, gidx, pl, pg, pr);
        exp_pred = exp_branch(ins) & s_pred[0];
        #1;
        check("branchD", branchD, exp_branch(ins));
        check("pred_takeD", pred_takeD, exp_pred);
    endtask

    initial begin
        logic [31:0] pa, pb, pp, pcs[8], ins, pcf_r, pcm_r;
        logic        tk, r;
        int          hits, held;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        instrD = BEQ; pcF = 32'h0040_0010;
        #1;
        check("rst_branchD", branchD, 1);
        check("rst_pred", pred_takeD, 0);
        rst = 1'b1;
        step(32'h0040_0010, BEQ, 32'd0, 1'b0, 1'b0);
        check("post_rst_pred", pred_takeD, 1);

        step(32'h0040_0010, 32'h0411_0000, 32'd0, 1'b0, 1'b0);
        check("dec_bgezal", branchD, 1);
        step(32'h0040_0010, 32'h0800_0000, 32'd0, 1'b0, 1'b0);
        check("dec_j", branchD, 0);
        step(32'h0040_0010, 32'h0402_0000, 32'd0, 1'b0, 1'b0);
        check("dec_regimm_rt2", branchD, 0);

        // Local pattern T,T,N: lookup, two bubbles, then resolve in Memory.
        pp = 32'h0040_0010;
        for (int it = 0; it < 30; it++) begin
            tk = (it % 3) != 2;
            step(pp, BEQ, 32'd0, 1'b0, 1'b0);
            if (it >= 20) check("local_pattern", pred_takeD, tk);
            step(FILLPC, NOP, 32'd0, 1'b0, 1'b0);
            step(FILLPC, NOP, 32'd0, 1'b0, 1'b0);
            step(FILLPC, NOP, pp, 1'b1, tk);
        end

        // B repeats A's random outcome: only global history can predict B.
        pa = 32'h0040_0100;
        pb = 32'h0040_0204;
        hits = 0;
        for (int it = 0; it < 150; it++) begin
            r = 1'($urandom_range(0, 1));
            step(pa, BEQ, 32'd0, 1'b0, 1'b0);
            step(FILLPC, NOP, 32'd0, 1'b0, 1'b0);
            step(FILLPC, NOP, 32'd0, 1'b0, 1'b0);
            step(FILLPC, NOP, pa, 1'b1, r);
            step(pb, BEQ, 32'd0, 1'b0, 1'b0);
            if (it >= 100 && pred_takeD == r) hits++;
            step(FILLPC, NOP, 32'd0, 1'b0, 1'b0);
            step(FILLPC, NOP, 32'd0, 1'b0, 1'b0);
            step(FILLPC, NOP, pb, 1'b1, r);
        end
        check("choice_global_hits", (hits >= 40) ? 1 : 0, 1);

        step(pa, BEQ, 32'd0, 1'b0, 1'b0);
        held = exp_pred;
        stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(pb + 32'(i * 4), BEQ, 32'd0, 1'b0, 1'b0);
            check("stall_hold", pred_takeD, held);
        end
        stallD = 1'b0;
        flushD = 1'b1;
        step(pa, BEQ, 32'd0, 1'b0, 1'b0);
        check("flush_zero", pred_takeD, 0);
        flushD = 1'b0;

        // Asynchronous reset mid-run, then read-before-write on the same PC.
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_pred", pred_takeD, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        pp = 32'h0040_0040;
        step(pp, BEQ, 32'd0, 1'b0, 1'b0);
        step(pp, BEQ, 32'd0, 1'b0, 1'b0);
        step(FILLPC, NOP, 32'd0, 1'b0, 1'b0);
        step(FILLPC, NOP, pp, 1'b1, 1'b0);
        step(pp, BEQ, pp, 1'b1, 1'b1);
        check("rbw_old_value", pred_takeD, 0);
        step(pp, BEQ, 32'd0, 1'b0, 1'b0);
        check("rbw_new_value", pred_takeD, 1);

        pcs[0] = 32'h0040_0000; pcs[1] = 32'h0040_0004; pcs[2] = 32'h0040_1000;
        pcs[3] = 32'h0040_0400; pcs[4] = 32'h0040_0010; pcs[5] = 32'h0040_0100;
        pcs[6] = 32'h0040_0204; pcs[7] = 32'h0040_0008;
        for (int n = 0; n < 1500; n++) begin
            stallD = ($urandom_range(0, 7) == 0);
            flushD = ($urandom_range(0, 15) == 0);
            stallE = ($urandom_range(0, 7) == 0);
            flushE = ($urandom_range(0, 15) == 0);
            stallM = ($urandom_range(0, 7) == 0);
            flushM = ($urandom_range(0, 15) == 0);
            ins = $urandom;
            ins[31:26] = 6'($urandom_range(0, 8));
            if ($urandom_range(0, 1) == 1) ins[20:16] = 5'($urandom_range(0, 1) + 16 * $urandom_range(0, 1));
            pcf_r = ($urandom_range(0, 9) == 0) ? $urandom : pcs[$urandom_range(0, 7)];
            pcm_r = ($urandom_range(0, 9) == 0) ? $urandom : pcs[$urandom_range(0, 7)];
            step(pcf_r, ins, pcm_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        stallD = 1'b0; flushD = 1'b0; stallE = 1'b0; flushE = 1'b0; stallM = 1'b0; flushM = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tournament_bpu.md
# tournament_bpu

Parametrised tournament branch predictor for the 5-stage MIPS pipeline. It combines three structures, all looked up with `pcF` in Fetch:
- a local two-level predictor (per-PC history table feeding a pattern table);
- a global predictor (global history register, optionally XOR-hashed with the PC);
- a choice table that selects between the local and global predictions.

The prediction is delivered in Decode, gated by an internal branch decode of `instrD`. The lookup snapshot travels D→E→M inside the block, so the Memory-stage update trains exactly the entries used for prediction.

## Interface
Parameters:
- `LHT_DEPTH`, 10: log2 entries of the local history table; indexed by `pc[LHT_DEPTH+1:2]`.
- `LHR_WIDTH`, 6: local history bits per entry; the local PHT has 2^LHR_WIDTH counters.
- `GHR_WIDTH`, 8: global history bits; the global PHT has 2^GHR_WIDTH counters.
- `CPHT_DEPTH`, 8: log2 entries of the choice table; indexed by `pc[CPHT_DEPTH+1:2]`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `pcF`  in  32  Fetch PC.
- `instrD`  in  32  Decode instruction word.
- `stallD`, `flushD`  in  1 each  Decode register control.
- `stallE`, `flushE`  in  1 each  Execute register control.
- `stallM`, `flushM`  in  1 each  Memory register control.
- `pcM`  in  32  Memory-stage PC.
- `branchM`  in  1  Memory-stage instruction is a conditional branch.
- `actual_takeM`  in  1  resolved direction of that branch.
- `branchD`  out  1  Decode instruction is a conditional branch.
- `pred_takeD`  out  1  final prediction: taken.

## Operation
- **Counter encoding** for every 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The MSB is the prediction. Counters increment on taken and decrement on not-taken, saturating at 11 and 00.
- **`branchD` decode.** High for opcode 000100 (beq), 000101 (bne), 000110 (blez) or 000111 (bgtz). Also high for opcode 000001 with rt ∈ {00000, 00001, 10000, 10001}. All other encodings give 0.
- **Local path.** `lhr = LHT[pcF[LHT_DEPTH+1:2]]`; `pl = LPHT[lhr][1]`.
- **Global path.** The global index is `gidx = GHR ^ pcF[GHR_WIDTH+1:2]` (see Configuration); `pg = GPHT[gidx][1]`.
- **Choice.** `c = CPHT[pcF[CPHT_DEPTH+1:2]][1]`; `predF = c ? pg : pl`. A choice MSB of 1 selects the global prediction.
- **Snapshot pipeline.** The snapshot `{lhr, gidx, pl, pg, predF}` advances F→D→E→M. Each stage register loads when its stall input is 0 and clears to all-zero when its flush input is 1. Flush has priority over stall.
- **Decode output.** `pred_takeD = branchD & predD`.
- **Update** happens only on a cycle with `branchM=1`, using `pcM` and the M snapshot. Let `t = actual_takeM`.
  - The LHT entry at `pcM[LHT_DEPTH+1:2]` becomes `{lhr[LHR_WIDTH-2:0], t}`.
  - `LPHT[lhrM]` and `GPHT[gidxM]` each train toward `t`.
  - `GHR` becomes `{GHR[GHR_WIDTH-2:0], t}`. GHR is non-speculative and changes only here.
  - The CPHT entry at `pcM[CPHT_DEPTH+1:2]` trains only when `plM != pgM`: increment if `pgM == t`, decrement if `plM == t`.
- **No training when `branchM=0`.** No table, GHR or counter changes.

## Timing
- **Reset (`rst`=0, asynchronous)** sets:
  - every LHT entry and GHR to 0;
  - every LPHT and GPHT counter to 10;
  - every CPHT counter to 01;
  - all snapshot registers to 0, so `pred_takeD` is 0.
  
  `branchD` is combinational from `instrD`. Reset asserted mid-operation discards all history immediately.
- **Lookup.** The lookup is combinational in F. The prediction is visible as `pred_takeD` one cycle after `pcF` is presented, provided D is not stalled.
- **Update latency.** An update on edge N is visible to the lookup in cycle N+1.
- **Same-cycle update and lookup of the same entry.** The lookup reads the pre-update value (read-before-write).
- **Stalled stage.** The snapshot holds; `pred_takeD` stays stable while `stallD=1`.
- **Counter wrap.** Saturation, never wrap: 11 stays 11 on taken, 00 stays 00 on not-taken.
- **History wrap.** The oldest bit of LHT entries and GHR is discarded on each shift.

## Configuration
- **`BPU_GSHARE_EN` defined:** `gidx = GHR ^ pcF[GHR_WIDTH+1:2]` (gshare).
- **Not defined:** `gidx = GHR` (GAg). The PC does not participate in global indexing.
- In both modes the snapshot carries `gidx`, so the update always trains the entry that was read.

## Test plan
- **Reset defaults.** Hold `rst`=0, then release. Present `instrD`=beq (0x10000000) and any `pcF` → `branchD`=1 and `pred_takeD`=0 (choice 01 selects local, LPHT[0]=10, so `pl`=1). Note that `pred_takeD` is 1 from the cycle after release, because the registered snapshot is zero only during reset.
- **Decode coverage.** Drive `instrD` = 0x04110000 (bgezal) → `branchD`=1. Drive 0x08000000 (j) → `branchD`=0. Drive 0x04020000 (REGIMM, rt=00010) → `branchD`=0.
- **Local pattern learning.** Send a branch at `pcM`=0x00400010 through M with the repeating pattern T,T,N for 30 iterations → after warm-up, a lookup at `pcF`=0x00400010 predicts the pattern exactly.
- **Choice training.** Alternate two branches so that global predicts correctly where local does not → the CPHT entry saturates at 11 and `pred_takeD` follows `pg`.
- **Hazards.** Hold `stallD`=1 for 3 cycles → `pred_takeD` unchanged. Assert `flushD`=1 → `pred_takeD`=0 in the next cycle.
- **Same-cycle conflict.** Update and lookup the same PC in one cycle, with LPHT at 01 and `t`=1 → the lookup returns 0, and the next cycle returns 1 (10). With `BPU_GSHARE_EN` undefined, two PCs with equal GHR share a GPHT entry.
